gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Synchronises, debounces and edge-detects asynchronous board inputs (slide switches, push buttons) before they reach the sigma SoC's GPIO input bus and button IRQ line. It sits between the board top-level pins and `sigma`, in the 80 MHz system clock domain. It provides a clean per-bit level and single-cycle rise/fall pulses, so the core never sees metastable or bouncing inputs.

## Interface
- `WIDTH`, 16 — number of independent input channels.
- `DEBOUNCE_CYCLES`, 800000 — consecutive stable cycles needed to accept a new level (10 ms at 80 MHz); legal range is 1 to 2^24.
- `RESET_LEVEL`, 0 — `WIDTH`-bit value loaded into the synchroniser and `level_o` on reset.
- `clk_i` input 1 — system clock.
- `arst_i` input 1 — reset; asynchronous and active-high.
- `raw_i` input `WIDTH` — asynchronous raw pin inputs.
- `level_o` output `WIDTH` — debounced level, one bit per channel.
- `rise_o` output `WIDTH` — one-cycle pulse when a channel's `level_o` goes 0→1.
- `fall_o` output `WIDTH` — one-cycle pulse when a channel's `level_o` goes 1→0.
- `changed_o` output 1 — OR-reduction of `rise_o | fall_o`, registered in the same cycle as the pulses.

## Operation
- Reset (async assert; release is synchronised by the top level):
  - synchroniser flops = `RESET_LEVEL`;
  - `level_o` = `RESET_LEVEL`;
  - all counters = 0;
  - `rise_o`, `fall_o` and `changed_o` = 0.
  - Because the synchroniser resets to `RESET_LEVEL`, no pulse is produced after reset unless the pins really differ from `RESET_LEVEL`.
- Per channel, the synchronised bit `s` is compared with `level_o[i]` at every clock:
  - if `s == level_o[i]`: the counter is cleared to 0;
  - if they differ and the counter equals `DEBOUNCE_CYCLES-1`: `level_o[i]` toggles, the counter clears, and `rise_o[i]` or `fall_o[i]` is set for exactly one cycle;
  - if they differ otherwise: the counter increments.
- Any single cycle of agreement during a pending change clears the counter, so glitches shorter than `DEBOUNCE_CYCLES` are rejected completely.
- The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and saturates by construction; it never wraps.
- Channels are fully independent. Simultaneous transitions on several bits produce simultaneous pulses, and `changed_o` is a single pulse.
- `DEBOUNCE_CYCLES=1` degenerates to a pure synchroniser plus edge detector: the change is accepted on the first mismatch cycle.

## Timing
- Let edge 1 be the first rising `clk_i` edge that samples a new, stable `raw_i` value.
  - With the default 2-flop synchroniser, `level_o` and the pulse update on edge `DEBOUNCE_CYCLES+2`.
  - With the 3-flop synchroniser, they update on edge `DEBOUNCE_CYCLES+3`.
- `rise_o`, `fall_o` and `changed_o` are high for exactly one cycle, in the cycle where `level_o` shows its new value.
- Reset asserted mid-count: all state returns to reset values immediately. Nothing in flight survives.
- There is no handshake. Consumers sample pulses every cycle.

## Configuration
- `GPIO_INPUT_COND_SYNC3_EN`:
  - defined: each channel uses a 3-flop synchroniser, and all latencies grow by one cycle;
  - undefined (default): 2-flop synchroniser.
- Debounce and edge behaviour are otherwise identical in both builds.

## Test plan
- **Reset values:** `RESET_LEVEL=16'h00F0`, `raw_i=16'h00F0`, release reset and run 20 cycles → `level_o=16'h00F0`, with no pulse on `rise_o`, `fall_o` or `changed_o`.
- **Clean rise:** `DEBOUNCE_CYCLES=4`, `raw_i[0]` goes 0→1 before edge 1 → `level_o[0]=1` and `rise_o[0]=1` on edge 6 (edge 7 with `GPIO_INPUT_COND_SYNC3_EN`); `rise_o[0]=0` on edge 7.
- **Glitch reject:** `DEBOUNCE_CYCLES=4`, `raw_i[3]` high for 3 cycles then low → `level_o[3]` stays 0, and no pulse occurs.
- **Bounce then settle:** `raw_i[5]` toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → exactly one `rise_o[5]` pulse, 6 edges after the final 0→1 sample, and a single `changed_o` pulse.
- **Simultaneous fall:** `level_o=16'hFFFF`, then `raw_i=16'h0000` → `fall_o=16'hFFFF` for one cycle, with one `changed_o` pulse.
- **Reset mid-count:** assert `arst_i` at counter value 2 of 4 and release it with `raw_i` unchanged → the channel restarts from `RESET_LEVEL`, and a full `DEBOUNCE_CYCLES+2` cycles pass before any pulse.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Synchronises, debounces and edge-detects asynchronous board inputs.
// Each channel: N-flop synchroniser -> stable-cycle counter -> debounced
// level, with registered one-cycle rise/fall pulses and a combined
// changed pulse.
// Optional build macro: GPIO_INPUT_COND_SYNC3_EN selects a 3-flop
// synchroniser (default 2-flop); all latencies grow by one cycle.
module gpio_input_conditioner #(
  parameter int               WIDTH           = 16,
  parameter int               DEBOUNCE_CYCLES = 800000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

`ifdef GPIO_INPUT_COND_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // Counter only ever reaches DEBOUNCE_CYCLES-1 before clearing, so it
  // cannot wrap.
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [WIDTH-1:0] w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CW-1:0]          r_cnt;
      logic                   w_sync_bit;
      logic                   w_mismatch;

      assign w_sync_bit   = r_sync[SYNC_STAGES-1];
      assign w_mismatch   = (w_sync_bit != r_level[gi]);
      assign w_accept[gi] = w_mismatch && (r_cnt == CNT_LAST);

      // Synchroniser shift chain; resets to the channel's reset level so no
      // spurious edge appears after reset.
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          r_sync <= {SYNC_STAGES{RESET_LEVEL[gi]}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i[gi]};
        end
      end

      // Stable-cycle counter: any agreement cycle or an accepted change
      // restarts it; otherwise it counts the mismatch run.
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          r_cnt <= '0;
        end else if (!w_mismatch || w_accept[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  endgenerate

  // Debounced level and edge pulses, all updated on the acceptance edge so
  // pulses line up with the cycle where the new level is visible.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_level   <= RESET_LEVEL;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_level   <= r_level ^ w_accept;
      r_rise    <= w_accept & ~r_level;
      r_fall    <= w_accept & r_level;
      r_changed <= |w_accept;
    end
  end

  assign level_o   = r_level;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign changed_o = r_changed;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner
// (DEBOUNCE_CYCLES=4, RESET_LEVEL=16'h00F0).
module tb_gpio_input_conditioner;

  localparam int               W   = 16;
  localparam int               DB  = 4;
  localparam logic [W-1:0]     RL  = 16'h00F0;
`ifdef GPIO_INPUT_COND_SYNC3_EN
  localparam int               SYN = 3;
`else
  localparam int               SYN = 2;
`endif
  localparam int               LAT = DB + SYN;

  logic         clk;
  logic         arst;
  logic [W-1:0] raw;
  logic [W-1:0] level;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  int checks   = 0;
  int failures = 0;

  gpio_input_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB),
    .RESET_LEVEL(RL)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .raw_i(raw),
    .level_o(level),
    .rise_o(rise),
    .fall_o(fall),
    .changed_o(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_lvl,
                         input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
    chk({tag, "_level"}, level, e_lvl);
    chk({tag, "_rise"}, rise, e_rise);
    chk({tag, "_fall"}, fall, e_fall);
    chk({tag, "_changed"}, {15'd0, changed}, {15'd0, |(e_rise | e_fall)});
    $display("step %-10s t=%0t raw=%h level=%h rise=%h fall=%h changed=%b",
             tag, $time, raw, level, rise, fall, changed);
  endtask

  initial begin
    logic [W-1:0] lvl;

    // Reset values
    arst = 1'b1;
    raw  = RL;
    tick();
    tick();
    chk_all("rst_held", RL, '0, '0);
    arst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_all("rst_idle", RL, '0, '0);
    end

    // Clean rise on bit 0
    lvl = RL;
    raw = RL | 16'h0001;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk_all("rise0", (k >= LAT) ? (lvl | 16'h0001) : lvl,
              (k == LAT) ? 16'h0001 : 16'h0000, '0);
    end
    lvl = lvl | 16'h0001;

    // Glitch on bit 3 for 3 cycles is rejected
    raw = lvl | 16'h0008;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all("glitch_hi", lvl, '0, '0);
    end
    raw = lvl;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("glitch_lo", lvl, '0, '0);
    end

    // Bounce 1,0,1,0 then settle at 1 on bit 9 (0 at this point)
    for (int b = 0; b < 4; b++) begin
      raw = (b % 2 == 0) ? (lvl | 16'h0200) : lvl;
      tick();
      chk_all("bounce", lvl, '0, '0);
    end
    raw = lvl | 16'h0200;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      chk_all("settle", (k >= LAT) ? (lvl | 16'h0200) : lvl,
              (k == LAT) ? 16'h0200 : 16'h0000, '0);
    end
    lvl = lvl | 16'h0200;  // 16'h02F1

    // Drive all high: remaining zero bits rise together
    raw = 16'hFFFF;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk_all("all_hi", (k >= LAT) ? 16'hFFFF : lvl,
              (k == LAT) ? 16'hFD0E : 16'h0000, '0);
    end
    lvl = 16'hFFFF;

    // Simultaneous fall on every bit
    raw = 16'h0000;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk_all("sim_fall", (k >= LAT) ? 16'h0000 : lvl, '0,
              (k == LAT) ? 16'hFFFF : 16'h0000);
    end
    lvl = 16'h0000;

    // Reset mid-count: bit 0 pending, counter reaches 2 after SYN+2 edges
    raw = 16'h0001;
    for (int k = 1; k <= SYN + 2; k++) begin
      tick();
      chk_all("pend", lvl, '0, '0);
    end
    #2;
    arst = 1'b1;
    #1;
    chk_all("mid_rst", RL, '0, '0);
    tick();
    chk_all("mid_rst2", RL, '0, '0);
    arst = 1'b0;
    // After restart from RESET_LEVEL: bit 0 rises, bits 4-7 fall, both after
    // a full latency.
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      chk_all("restart", (k >= LAT) ? 16'h0001 : RL,
              (k == LAT) ? 16'h0001 : 16'h0000,
              (k == LAT) ? 16'h00F0 : 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
